sdram_read_arbiter: RTL and testbench

- Shares the single 64-bit Avalon-MM SDRAM port between two masters.
  - Master 0 is the frame buffer streamer: read-only, latency-critical, high priority.
  - Master 1 is the rasterizer: reads and writes, low priority.
- Handles fixed priority with starvation relief, grant locking while the slave stalls, and in-order routing of pipelined read data back to the issuing master through a tag FIFO.

---
 rtl/sdram_read_arbiter_if.sv | 27 ++
 rtl/sdram_read_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_read_arbiter_if.sv
`default_nettype none
// ======================================================================
// sdram_read_arbiter_if : one 64-bit Avalon-MM port (master/slave views)
// Revision 1.0
// ======================================================================
interface sdram_read_arbiter_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/sdram_read_arbiter.sv
`default_nettype none
// ======================================================================
// sdram_read_arbiter : two-master SDRAM port arbiter with tag-routed reads
// Revision 1.0
// ======================================================================
module sdram_read_arbiter #(
  parameter int MAX_PENDING      = 16,
  parameter int MAX_PENDING_LOG2 = 4,
  parameter int STARVE_LIMIT     = 8
) (
  input  wire logic                  clock,
  input  wire logic                  reset_n,
  sdram_read_arbiter_if.slave        m0,
  sdram_read_arbiter_if.slave        m1,
  sdram_read_arbiter_if.master       s,
  output logic [MAX_PENDING_LOG2:0]  pending,
  output logic                       error
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]       STARVE_MAX   = STARVE_W'(STARVE_LIMIT);
  localparam logic [MAX_PENDING_LOG2:0] PENDING_FULL = (MAX_PENDING_LOG2 + 1)'(MAX_PENDING);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_M0   = 2'd1,
    GRANT_M1   = 2'd2
  } grant_t;

  grant_t                      grant;
  grant_t                      grant_next;
  logic                        lock;
  logic                        lock_next;
  logic                        hold_grant;
  logic [STARVE_W-1:0]         starve;
  logic [STARVE_W-1:0]         starve_next;
  logic [MAX_PENDING-1:0]      tags;
  logic [MAX_PENDING_LOG2-1:0] wr_ptr;
  logic [MAX_PENDING_LOG2-1:0] rd_ptr;

  logic        req0;
  logic        req1;
  logic        full;
  logic        cmd_read;
  logic        cmd_write;
  logic        accept;
  logic        push;
  logic        pop;
  logic        head_tag;
  logic [28:0] cmd_address;
  logic [63:0] cmd_writedata;
  logic [7:0]  cmd_byteenable;

  assign req0 = m0.read;
  assign req1 = m1.read | m1.write;
  assign full = (pending == PENDING_FULL);

  always_comb begin
    cmd_read       = 1'b0;
    cmd_write      = 1'b0;
    cmd_address    = '0;
    cmd_writedata  = '0;
    cmd_byteenable = '0;
    case (grant)
      GRANT_M0: begin
        cmd_read       = m0.read & ~full;
        cmd_address    = m0.address;
        cmd_byteenable = 8'hFF;
      end
      GRANT_M1: begin
        cmd_read       = m1.read & ~full;
        cmd_write      = m1.write;
        cmd_address    = m1.address;
        cmd_writedata  = m1.writedata;
        cmd_byteenable = m1.byteenable;
      end
      default: ;
    endcase
  end

  assign s.address    = cmd_address;
  assign s.burstcount = 8'h01;
  assign s.read       = cmd_read;
  assign s.write      = cmd_write;
  assign s.writedata  = cmd_writedata;
  assign s.byteenable = cmd_byteenable;

  assign m0.waitrequest = (grant == GRANT_M0) ? (s.waitrequest | (m0.read & full)) : 1'b1;
  assign m1.waitrequest = (grant == GRANT_M1) ? (s.waitrequest | (m1.read & full)) : 1'b1;

  assign accept    = (cmd_read | cmd_write) & ~s.waitrequest;
  assign lock_next = (cmd_read | cmd_write) & s.waitrequest;
  // A stalled command may never be switched away from, even for one cycle.
  assign hold_grant = lock_next | (lock & ~accept);

  always_comb begin
    starve_next = starve;
    if (!req1 || (accept && grant == GRANT_M1)) begin
      starve_next = '0;
    end else if (accept && grant == GRANT_M0 && starve != STARVE_MAX) begin
      starve_next = starve + 1'b1;
    end
  end

  // Master 0 keeps the port while it streams; master 1 keeps it only while
  // master 0 is quiet, so a forced master 1 grant lasts exactly one accept.
  always_comb begin
    grant_next = grant;
    if (!hold_grant) begin
      if (grant == GRANT_M0 && accept && req1 && starve_next == STARVE_MAX) begin
        grant_next = GRANT_M1;
      end else if (grant == GRANT_M0 && req0) begin
        grant_next = GRANT_M0;
      end else if (grant == GRANT_M1 && req1 && !req0) begin
        grant_next = GRANT_M1;
      end else if (req0) begin
        grant_next = GRANT_M0;
      end else if (req1) begin
        grant_next = GRANT_M1;
      end else begin
        grant_next = GRANT_NONE;
      end
    end
  end

  assign push     = accept & cmd_read;
  assign pop      = s.readdatavalid & (pending != '0);
  assign head_tag = tags[rd_ptr];

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & ~head_tag;
  assign m1.readdatavalid = pop & head_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= GRANT_NONE;
      lock    <= 1'b0;
      starve  <= '0;
      tags    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      error   <= 1'b0;
    end else begin
      grant  <= grant_next;
      lock   <= lock_next;
      starve <= starve_next;
      if (push) begin
        tags[wr_ptr] <= (grant == GRANT_M1);
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
      if (s.readdatavalid && pending == '0) begin
        error <= 1'b1;
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, m0.burstcount, m0.write, m0.writedata, m0.byteenable,
                           m1.burstcount};

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_arbiter.sv
`default_nettype none
// ======================================================================
// tb_sdram_read_arbiter : scoreboard bench with a 3-cycle in-order slave
// Revision 1.0
// ======================================================================
module tb_sdram_read_arbiter;
  localparam int MAX_PENDING      = 16;
  localparam int MAX_PENDING_LOG2 = 4;
  localparam int STARVE_LIMIT     = 8;
  localparam int LAT              = 3;

  typedef struct {
    logic [63:0] data;
    int          due;
  } ret_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] pending;
  logic       error;

  sdram_read_arbiter_if m0_bus ();
  sdram_read_arbiter_if m1_bus ();
  sdram_read_arbiter_if s_bus ();

  sdram_read_arbiter #(
    .MAX_PENDING      (MAX_PENDING),
    .MAX_PENDING_LOG2 (MAX_PENDING_LOG2),
    .STARVE_LIMIT     (STARVE_LIMIT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .pending (pending),
    .error   (error)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          max_pending = 0;
  int          rdv0_cnt = 0;
  int          rdv1_cnt = 0;
  bit          hold_rdv = 1'b0;
  bit          release_one = 1'b0;
  bit          spurious = 1'b0;
  bit          acc0 = 1'b0;
  bit          acc1 = 1'b0;
  ret_t        sq[$];
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  int          acc_log[$];

  function automatic logic [63:0] mem_data(input logic [28:0] a);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  // One clock cycle: slave model drives returns, scoreboard observes, clock advances.
  task automatic step();
    logic        present;
    logic [63:0] want;
    present = 1'b0;
    if (spurious) begin
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata      = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (sq.size() > 0 && sq[0].due <= cyc && (!hold_rdv || release_one)) begin
      present             = 1'b1;
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata      = sq[0].data;
    end else begin
      s_bus.readdatavalid = 1'b0;
      s_bus.readdata      = '0;
    end
    #1;
    acc0 = m0_bus.read && !m0_bus.waitrequest;
    acc1 = (m1_bus.read || m1_bus.write) && !m1_bus.waitrequest;
    if (acc0) begin
      exp0.push_back(mem_data(m0_bus.address));
      acc_log.push_back(0);
    end
    if (acc1) begin
      if (m1_bus.read) exp1.push_back(mem_data(m1_bus.address));
      acc_log.push_back(1);
    end
    if (s_bus.read && !s_bus.waitrequest)
      sq.push_back('{data: mem_data(s_bus.address), due: cyc + LAT});
    if (int'(pending) > max_pending) max_pending = int'(pending);
    if (spurious) begin
      checks++;
      if (m0_bus.readdatavalid !== 1'b0 || m1_bus.readdatavalid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_rdv m0=%b m1=%b need 0 0", m0_bus.readdatavalid, m1_bus.readdatavalid);
      end
    end
    if (present) begin
      checks++;
      if ((m0_bus.readdatavalid ^ m1_bus.readdatavalid) !== 1'b1) begin
        errors++;
        $display("FAIL route_onehot m0=%b m1=%b need exactly one", m0_bus.readdatavalid, m1_bus.readdatavalid);
      end
    end
    if (m0_bus.readdatavalid === 1'b1) begin
      checks++;
      rdv0_cnt++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL m0_rdv_unexpected data=%h need no return", m0_bus.readdata);
      end else begin
        want = exp0.pop_front();
        if (m0_bus.readdata !== want) begin
          errors++;
          $display("FAIL m0_readdata got=%h need=%h", m0_bus.readdata, want);
        end
      end
    end
    if (m1_bus.readdatavalid === 1'b1) begin
      checks++;
      rdv1_cnt++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL m1_rdv_unexpected data=%h need no return", m1_bus.readdata);
      end else begin
        want = exp1.pop_front();
        if (m1_bus.readdata !== want) begin
          errors++;
          $display("FAIL m1_readdata got=%h need=%h", m1_bus.readdata, want);
        end
      end
    end
    if (present) begin
      void'(sq.pop_front());
      release_one = 1'b0;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    m0_bus.read  = 1'b0;
    m1_bus.read  = 1'b0;
    m1_bus.write = 1'b0;
    hold_rdv     = 1'b0;
    release_one  = 1'b0;
    n = 0;
    while ((sq.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && n < 80) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 80 || pending !== 5'd0) begin
      errors++;
      $display("FAIL drain pending=%0d left0=%0d left1=%0d need all 0", pending, exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
         m0_bus.readdatavalid, m1_bus.readdatavalid, pending, error} !== {6'b001100, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state rd=%b wr=%b w0=%b w1=%b v0=%b v1=%b pend=%0d err=%b need 0 0 1 1 0 0 0 0",
               s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
               m0_bus.readdatavalid, m1_bus.readdatavalid, pending, error);
    end
    @(negedge clock);
    reset_n     = 1'b1;
    m0_bus.read = 1'b1;
    #1;
    checks++;
    if (m0_bus.waitrequest !== 1'b1 || s_bus.read !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant_none w0=%b rd=%b need 1 0", m0_bus.waitrequest, s_bus.read);
    end
    m0_bus.read = 1'b0;
    @(negedge clock);
    step();
  endtask

  task automatic test_m0_stream();
    int accepts = 0;
    int bubbles = 0;
    rdv0_cnt = 0;
    rdv1_cnt = 0;
    max_pending = 0;
    m0_bus.address = 29'h100;
    m0_bus.read    = 1'b1;
    for (int n = 0; n < 150 && accepts < 100; n++) begin
      step();
      if (acc0) begin
        accepts++;
        m0_bus.address = m0_bus.address + 1'b1;
      end else if (accepts > 0) begin
        bubbles++;
      end
    end
    m0_bus.read = 1'b0;
    checks++;
    if (accepts != 100 || bubbles != 0) begin
      errors++;
      $display("FAIL stream_accepts got=%0d bubbles=%0d need 100 0", accepts, bubbles);
    end
    drain();
    checks++;
    if (rdv0_cnt != 100 || rdv1_cnt != 0) begin
      errors++;
      $display("FAIL stream_returns m0=%0d m1=%0d need 100 0", rdv0_cnt, rdv1_cnt);
    end
    checks++;
    if (max_pending != 3) begin
      errors++;
      $display("FAIL stream_peak_pending got=%0d need 3", max_pending);
    end
  endtask

  task automatic test_starvation();
    int want;
    acc_log.delete();
    rdv1_cnt = 0;
    m0_bus.address = 29'h2000;
    m1_bus.address = 29'h3000;
    m0_bus.read    = 1'b1;
    m1_bus.read    = 1'b1;
    for (int n = 0; n < 100 && acc_log.size() < 36; n++) begin
      step();
      if (acc0) m0_bus.address = m0_bus.address + 1'b1;
      if (acc1) m1_bus.address = m1_bus.address + 1'b1;
    end
    checks++;
    if (acc_log.size() < 36) begin
      errors++;
      $display("FAIL starve_budget accepts=%0d need 36", acc_log.size());
    end else begin
      for (int k = 0; k < 36; k++) begin
        want = (k % 9 == 8) ? 1 : 0;
        checks++;
        if (acc_log[k] != want) begin
          errors++;
          $display("FAIL starve_pattern idx=%0d got=M%0d need=M%0d", k, acc_log[k], want);
        end
      end
    end
    drain();
    checks++;
    if (rdv1_cnt != 4) begin
      errors++;
      $display("FAIL starve_m1_returns got=%0d need 4", rdv1_cnt);
    end
  endtask

  task automatic test_lock();
    m1_bus.address    = 29'h0AB_CDEF;
    m1_bus.writedata  = 64'h0123_4567_89AB_CDEF;
    m1_bus.byteenable = 8'h5A;
    m1_bus.write      = 1'b1;
    s_bus.waitrequest = 1'b1;
    step();
    m0_bus.address = 29'h4000;
    m0_bus.read    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({s_bus.write, s_bus.read, s_bus.address, s_bus.writedata, s_bus.byteenable,
           m0_bus.waitrequest, m1_bus.waitrequest} !==
          {2'b10, 29'h0AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h5A, 2'b11}) begin
        errors++;
        $display("FAIL lock_hold cyc=%0d wr=%b rd=%b addr=%h data=%h be=%h w0=%b w1=%b need 1 0 0abcdef 0123456789abcdef 5a 1 1",
                 i, s_bus.write, s_bus.read, s_bus.address, s_bus.writedata, s_bus.byteenable,
                 m0_bus.waitrequest, m1_bus.waitrequest);
      end
      step();
    end
    s_bus.waitrequest = 1'b0;
    #1;
    checks++;
    if (m1_bus.waitrequest !== 1'b0 || s_bus.write !== 1'b1) begin
      errors++;
      $display("FAIL lock_release w1=%b wr=%b need 0 1", m1_bus.waitrequest, s_bus.write);
    end
    step();
    m1_bus.write = 1'b0;
    #1;
    checks++;
    if (m0_bus.waitrequest !== 1'b0 || s_bus.read !== 1'b1 || s_bus.address !== 29'h4000 ||
        s_bus.byteenable !== 8'hFF) begin
      errors++;
      $display("FAIL lock_then_m0 w0=%b rd=%b addr=%h be=%h need 0 1 4000 ff",
               m0_bus.waitrequest, s_bus.read, s_bus.address, s_bus.byteenable);
    end
    step();
    drain();
  endtask

  task automatic test_full();
    int accepts = 0;
    bit got_write = 1'b0;
    hold_rdv = 1'b1;
    m0_bus.address = 29'h5000;
    m0_bus.read    = 1'b1;
    for (int n = 0; n < 24; n++) begin
      step();
      if (acc0) begin
        accepts++;
        m0_bus.address = m0_bus.address + 1'b1;
      end
    end
    checks++;
    if (accepts != MAX_PENDING) begin
      errors++;
      $display("FAIL full_accepts got=%0d need %0d", accepts, MAX_PENDING);
    end
    #1;
    checks++;
    if (s_bus.read !== 1'b0 || m0_bus.waitrequest !== 1'b1 || pending !== 5'd16) begin
      errors++;
      $display("FAIL full_block rd=%b w0=%b pend=%0d need 0 1 16", s_bus.read, m0_bus.waitrequest, pending);
    end
    m0_bus.read       = 1'b0;
    m1_bus.address    = 29'h7000;
    m1_bus.writedata  = 64'hCAFE_F00D_1234_5678;
    m1_bus.byteenable = 8'h0F;
    m1_bus.write      = 1'b1;
    for (int n = 0; n < 6 && !got_write; n++) begin
      step();
      if (acc1) got_write = 1'b1;
    end
    checks++;
    if (!got_write || pending !== 5'd16) begin
      errors++;
      $display("FAIL full_write accepted=%b pend=%0d need 1 16", got_write, pending);
    end
    m1_bus.write = 1'b0;
    m0_bus.read  = 1'b1;
    step();
    #1;
    checks++;
    if (m0_bus.waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL full_still_blocked w0=%b need 1", m0_bus.waitrequest);
    end
    release_one = 1'b1;
    step();
    checks++;
    if (acc0 !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_same_cycle accepted=%b need 0", acc0);
    end
    step();
    checks++;
    if (acc0 !== 1'b1) begin
      errors++;
      $display("FAIL full_one_slot accepted=%b need 1", acc0);
    end
    m0_bus.address = m0_bus.address + 1'b1;
    accepts = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (acc0) accepts++;
    end
    checks++;
    if (accepts != 0) begin
      errors++;
      $display("FAIL full_refill accepts=%0d need 0", accepts);
    end
    drain();
  endtask

  task automatic test_error();
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    checks++;
    if (error !== 1'b1 || pending !== 5'd0) begin
      errors++;
      $display("FAIL error_set err=%b pend=%0d need 1 0", error, pending);
    end
    repeat (3) step();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky err=%b need 1", error);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (error !== 1'b0 || m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1 ||
        s_bus.read !== 1'b0 || s_bus.write !== 1'b0) begin
      errors++;
      $display("FAIL error_reset err=%b w0=%b w1=%b rd=%b wr=%b need 0 1 1 0 0",
               error, m0_bus.waitrequest, m1_bus.waitrequest, s_bus.read, s_bus.write);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int accepts = 0;
    hold_rdv = 1'b1;
    m0_bus.address = 29'h6000;
    m0_bus.read    = 1'b1;
    for (int n = 0; n < 20 && accepts < 5; n++) begin
      step();
      if (acc0) begin
        accepts++;
        m0_bus.address = m0_bus.address + 1'b1;
      end
    end
    m0_bus.read = 1'b0;
    checks++;
    if (accepts != 5 || pending !== 5'd5) begin
      errors++;
      $display("FAIL midreset_setup accepts=%0d pend=%0d need 5 5", accepts, pending);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pending !== 5'd0 || m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1 ||
        s_bus.read !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async pend=%0d w0=%b w1=%b rd=%b need 0 1 1 0",
               pending, m0_bus.waitrequest, m1_bus.waitrequest, s_bus.read);
    end
    sq.delete();
    exp0.delete();
    exp1.delete();
    hold_rdv    = 1'b0;
    m0_bus.read = 1'b1;
    #1;
    checks++;
    if (s_bus.read !== 1'b0 || m0_bus.waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL midreset_held rd=%b w0=%b need 0 1", s_bus.read, m0_bus.waitrequest);
    end
    @(negedge clock);
    reset_n     = 1'b1;
    m0_bus.read = 1'b0;
    step();
    step();
    checks++;
    if (s_bus.read !== 1'b0 || pending !== 5'd0) begin
      errors++;
      $display("FAIL midreset_idle rd=%b pend=%0d need 0 0", s_bus.read, pending);
    end
    m0_bus.read = 1'b1;
    #1;
    checks++;
    if (s_bus.read !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first_req rd=%b need 0", s_bus.read);
    end
    step();
    checks++;
    if (s_bus.read !== 1'b1 || m0_bus.waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL midreset_regrant rd=%b w0=%b need 1 0", s_bus.read, m0_bus.waitrequest);
    end
    step();
    drain();
  endtask

  initial begin
    m0_bus.address = '0; m0_bus.burstcount = 8'h01; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
    m0_bus.writedata = '0; m0_bus.byteenable = 8'hFF;
    m1_bus.address = '0; m1_bus.burstcount = 8'h01; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
    m1_bus.writedata = '0; m1_bus.byteenable = 8'h00;
    s_bus.waitrequest = 1'b0; s_bus.readdata = '0; s_bus.readdatavalid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_m0_stream();
    test_starvation();
    test_lock();
    test_full();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d need completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
